// File: rtl/mux_n_1_pipe.sv
// N-input WIDTH-bit selector with a one-entry registered output and valid/ready on every port.
// Source is a fixed index (mode 0) or round-robin among valid inputs (mode 1); `MUX_SEL_ERR_EN adds sticky sel_err.
module mux_n_1_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
`ifdef MUX_SEL_ERR_EN
    ,
    output logic                  sel_err
`endif
);

    localparam int unsigned CAND_W = SEL_W + 1;
    localparam logic [CAND_W-1:0] N_IN_C = CAND_W'(N_IN);
    localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_ptr_nxt;
    logic              fix_vld;
    logic [SEL_W-1:0]  fix_idx;
    logic              rr_vld;
    logic [SEL_W-1:0]  rr_idx;
    logic [CAND_W-1:0] rr_cand;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  gnt_data;
    logic              can_load;
    logic              xfer_in;
    logic              xfer_out;

    // Fixed select: comparing against each legal index keeps an out-of-range sel from granting
    always_comb begin
        fix_vld = 1'b0;
        fix_idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                fix_vld = 1'b1;
                fix_idx = SEL_W'(i);
            end
        end
    end

    // Round-robin: first valid input at or after rr_ptr, wrapping modulo N_IN
    always_comb begin
        rr_vld  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            rr_cand = {1'b0, rr_ptr} + CAND_W'(k);
            if (rr_cand >= N_IN_C) begin
                rr_cand = rr_cand - N_IN_C;
            end
            if (!rr_vld && in_valid[rr_cand[SEL_W-1:0]]) begin
                rr_vld = 1'b1;
                rr_idx = rr_cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_vld  = mode ? rr_vld : fix_vld;
        gnt_idx  = mode ? rr_idx : fix_idx;
        can_load = !out_valid || out_ready;
        xfer_in  = rst_n && gnt_vld && can_load;
        xfer_out = out_valid && out_ready;
    end

    // Ready goes only to the granted source, and never while reset is asserted
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_ready[i] = xfer_in && (gnt_idx == SEL_W'(i));
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SEL_W'(1);
    end

    // Output register: reload on input transfer, otherwise drop valid once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
        end else if (xfer_out) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer_in && mode) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic sel_bad;

    always_comb begin
        sel_bad = !mode && (32'(sel) >= N_IN);
    end

    // Sticky out-of-range select flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (sel_bad) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Bench for mux_n_1_pipe: a 4-input and a 3-input instance share stimulus and are checked
// each cycle against a per-instance behavioural model (directed steps, then random traffic).
module tb_mux_n_1_pipe;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*W-1:0] in_data;
    logic [3*W-1:0] in_data3;
    logic [3:0]     in_valid;
    logic [2:0]     in_valid3;
    logic           mode;
    logic [1:0]     sel;
    logic           out_ready;

    logic [3:0]     in_ready4;
    logic [W-1:0]   out_data4;
    logic           out_valid4;
    logic [1:0]     out_src4;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic           out_valid3;
    logic [1:0]     out_src3;
`ifdef MUX_SEL_ERR_EN
    logic           sel_err4;
    logic           sel_err3;
`endif

    int checks = 0;
    int failures = 0;

    int         nn [2] = '{4, 3};
    bit         m_valid [2];
    logic [W-1:0] m_data [2];
    int         m_src [2];
    int         m_ptr [2];
    bit         m_err [2];

    always #5 clk = ~clk;

    assign in_data3  = in_data[3*W-1:0];
    assign in_valid3 = in_valid[2:0];

    mux_n_1_pipe #(.WIDTH(W), .N_IN(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .mode(mode), .sel(sel), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_src(out_src4)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(sel_err4)
`endif
    );

    mux_n_1_pipe #(.WIDTH(W), .N_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode), .sel(sel), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready), .out_src(out_src3)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(sel_err3)
`endif
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut_n%0d observed=0x%0h expected=0x%0h", tag, nn[d], obs, exp);
        end
    endtask

    // Grant from the selection rules, written as a plain search
    function automatic int exp_grant(int n, logic [3:0] v, bit md, int s, int ptr);
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            int i = (ptr + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_ready(int g, bit cl);
        return (g >= 0 && cl) ? (32'd1 << g) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_src[d]   = 0;
            m_ptr[d]   = 0;
            m_err[d]   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 0, 32'(out_valid4), 32'(m_valid[0]));
        chk("out_data",  0, out_data4,       m_data[0]);
        chk("out_src",   0, 32'(out_src4),   32'(m_src[0]));
        chk("out_valid", 1, 32'(out_valid3), 32'(m_valid[1]));
        chk("out_data",  1, out_data3,       m_data[1]);
        chk("out_src",   1, 32'(out_src3),   32'(m_src[1]));
`ifdef MUX_SEL_ERR_EN
        chk("sel_err",   0, 32'(sel_err4),   32'(m_err[0]));
        chk("sel_err",   1, 32'(sel_err3),   32'(m_err[1]));
`endif
    endtask

    // One clock with the inputs currently driven: check ready, advance model, check outputs
    task automatic step();
        int g [2];
        bit cl [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]  = exp_grant(nn[d], in_valid, mode, int'(sel), m_ptr[d]);
            cl[d] = !m_valid[d] || out_ready;
        end
        chk("in_ready", 0, 32'(in_ready4), exp_ready(g[0], cl[0]));
        chk("in_ready", 1, 32'(in_ready3), exp_ready(g[1], cl[1]));
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (g[d] >= 0 && cl[d]) begin
                m_data[d]  = in_data[g[d]*W +: W];
                m_src[d]   = g[d];
                m_valid[d] = 1'b1;
                if (mode) m_ptr[d] = (g[d] + 1) % nn[d];
            end else if (m_valid[d] && out_ready) begin
                m_valid[d] = 1'b0;
            end
            if (!mode && int'(sel) >= nn[d]) m_err[d] = 1'b1;
        end
        #1;
        check_outputs();
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge
    task automatic async_reset();
        @(negedge clk);
        in_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("in_ready_rst", 0, 32'(in_ready4), 32'd0);
        chk("in_ready_rst", 1, 32'(in_ready3), 32'd0);
        @(posedge clk);
        #1;
        check_outputs();
        in_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0;
        in_valid = 4'h0;
        mode = 1'b0;
        sel = 2'd0;
        out_ready = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load 17 then reset mid-cycle
        set_word(0, 32'd17);
        in_valid = 4'b0001;
        step();
        chk("tp1_loaded", 0, out_data4, 32'd17);
        async_reset();

        // Fixed select
        set_word(0, 32'd17);
        set_word(1, $urandom);
        set_word(2, 32'd6);
        set_word(3, $urandom);
        in_valid = 4'hF;
        mode = 1'b0;
        sel = 2'd2;
        step();
        chk("tp2_sel2_data", 0, out_data4, 32'd6);
        chk("tp2_sel2_src",  0, 32'(out_src4), 32'd2);
        sel = 2'd0;
        step();
        chk("tp2_sel0_data", 0, out_data4, 32'd17);

        // Back-pressure, then drain and reload on the same edge
        out_ready = 1'b0;
        repeat (3) step();
        chk("tp3_held", 0, out_data4, 32'd17);
        out_ready = 1'b1;
        set_word(0, 32'd99);
        step();
        chk("tp3_reload_valid", 0, 32'(out_valid4), 32'd1);
        chk("tp3_reload_data",  0, out_data4, 32'd99);

        // Round-robin, all valid then only in1/in3
        mode = 1'b1;
        in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("tp4_rr_all", 0, 32'(out_src4), 32'(k % 4));
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("tp4_rr_1_3", 0, 32'(out_src4), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Wrap from in3, idle, then in0 first
        in_valid = 4'b1000;
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        chk("tp5_idle", 0, 32'(out_valid4), 32'd0);
        in_valid = 4'b0001;
        step();
        chk("tp5_after_wrap", 0, 32'(out_src4), 32'd0);

        // Out-of-range select on the 3-input instance
        mode = 1'b0;
        sel = 2'd3;
        in_valid = 4'hF;
        step();
        chk("tp6_no_load", 1, 32'(out_valid3), 32'd0);
        sel = 2'd0;
        step();
        async_reset();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) set_word(i, $urandom);
            in_valid  = 4'($urandom);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) async_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
